data_sram_like_responder: RTL and testbench

- Memory-side responder for the SRAM-like data bus (req/addr_ok/data_ok) that the CPU's memory-access stage issues on.
- Owns a word-addressed backing array, accepts one request per cycle and returns responses strictly in order after a fixed latency.
- Flags misaligned accesses.
- Serves as the data-side slave in SoC-lite simulation and as the bench model for the CPU's bus master.

---
 rtl/data_sram_like_responder_if.sv | 36 +++
 rtl/data_sram_like_responder.sv | 196 +++++++++++++++++++
 tb/tb_data_sram_like_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/data_sram_like_responder_if.sv
// ----------------------------------------------------------------------------
// data_sram_like_responder_if
// SRAM-like data bus (req / addr_ok / data_ok) between the CPU memory-access
// stage (master) and the data-side memory responder (slave).
//   req, wr, size, addr, wstrb, wdata : request channel, master -> slave
//   stall_in                           : back-pressure from the bench, forces
//                                        addr_ok low
//   addr_ok                            : request accepted this cycle when req is high
//   data_ok, rdata                     : in-order response pulse and its read data
//   err, err_addr                      : sticky misalignment flag and the
//                                        address of the first misaligned request
// ----------------------------------------------------------------------------
interface data_sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stall_in;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;

    modport master (
        output req, wr, size, addr, wstrb, wdata, stall_in,
        input  addr_ok, data_ok, rdata, err, err_addr
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata, stall_in,
        output addr_ok, data_ok, rdata, err, err_addr
    );
endinterface

// File: rtl/data_sram_like_responder.sv
// ----------------------------------------------------------------------------
// data_sram_like_responder
// Memory-side responder for the SRAM-like data bus. It owns a word-addressed
// backing array and accepts at most one request per cycle. Responses come back
// strictly in acceptance order, RESP_LAT cycles after each request was
// accepted. Misaligned requests are still accepted and answered, but they
// neither write nor read the array, and they raise a sticky error.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active high; flushes the response queue and the
//           error state, leaves the array contents alone
//   bus   : slave side of data_sram_like_responder_if
// Parameters:
//   ADDR_W   : log2 of the array depth in 32-bit words (upper address bits alias)
//   DEPTH    : number of pending-response queue entries (>= 1)
//   RESP_LAT : cycles from the acceptance cycle to the data_ok cycle (>= 1)
// ----------------------------------------------------------------------------
module data_sram_like_responder #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 4,
    parameter int RESP_LAT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    data_sram_like_responder_if.slave    bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // The age only has to reach RESP_LAT-1, the value at which the head pops
    localparam int AGE_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(RESP_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Half needs bit 0 clear; word (and the reserved encoding 3) needs bits 1:0 clear
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lsb[0];
            default: bad = (lsb != 2'b00);
        endcase
        return bad;
    endfunction

    // Byte-lane merge of new write data into the old array word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Backing array: not reset, contents survive a reset pulse
    logic [31:0]       mem_q [2**ADDR_W];

    // Response queue storage and control
    logic [31:0]       ent_rdata_q [DEPTH];
    logic [31:0]       ent_rdata_d [DEPTH];
    logic [AGE_W-1:0]  ent_age_q   [DEPTH];
    logic [AGE_W-1:0]  ent_age_d   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              err_q,    err_d;
    logic [31:0]       err_addr_q, err_addr_d;

    logic [ADDR_W-1:0] word_idx_s;
    logic [31:0]       mem_rd_s;
    logic [31:0]       mem_wword_s;
    logic              mem_we_s;
    logic              misaligned_s;
    logic              pop_s;
    logic              addr_ok_s;
    logic              push_s;
    logic              unused_s;

    assign word_idx_s   = bus.addr[ADDR_W+1:2];
    assign mem_rd_s     = mem_q[word_idx_s];
    assign misaligned_s = is_misaligned(bus.size, bus.addr[1:0]);
    assign unused_s     = ^bus.addr[31:ADDR_W+2];

    // The head entry responds once it has aged RESP_LAT-1 cycles after its push edge
    assign pop_s     = (count_q != CNT_W'(0)) && (ent_age_q[rd_ptr_q] == AGE_LAST);
    // A pop frees a slot in the same cycle, so a full queue can still accept
    assign addr_ok_s = ~reset & ~bus.stall_in & ((count_q < CNT_FULL) | pop_s);
    assign push_s    = bus.req & addr_ok_s;

    assign mem_we_s    = push_s & bus.wr & ~misaligned_s;
    assign mem_wword_s = merge_bytes(mem_rd_s, bus.wdata, bus.wstrb);

    assign bus.addr_ok  = addr_ok_s;
    assign bus.data_ok  = pop_s;
    assign bus.rdata    = pop_s ? ent_rdata_q[rd_ptr_q] : 32'h0000_0000;
    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;

    // Queue next state: ageing, push/pop, pointer wrap and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_rdata_d[i] = ent_rdata_q[i];
            // Saturate so idle slots never wrap back to the pop value
            if (ent_age_q[i] == AGE_LAST) begin
                ent_age_d[i] = ent_age_q[i];
            end else begin
                ent_age_d[i] = ent_age_q[i] + AGE_W'(1);
            end
        end

        if (push_s) begin
            ent_age_d[wr_ptr_q] = AGE_W'(0);
            // Writes and misaligned reads respond with zero data
            if (bus.wr || misaligned_s) begin
                ent_rdata_d[wr_ptr_q] = 32'h0000_0000;
            end else begin
                ent_rdata_d[wr_ptr_q] = mem_rd_s;
            end
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky error: the address is captured only by the first misaligned request
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (push_s && misaligned_s) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_addr_d = bus.addr;
            end else begin
                err_addr_d = err_addr_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    // Queue and error state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= PTR_W'(0);
            wr_ptr_q   <= PTR_W'(0);
            count_q    <= CNT_W'(0);
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rdata_q[i] <= 32'h0000_0000;
                ent_age_q[i]   <= AGE_W'(0);
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rdata_q[i] <= ent_rdata_d[i];
                ent_age_q[i]   <= ent_age_d[i];
            end
        end
    end

    // Array write at the acceptance edge, so a read accepted next cycle sees it
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[word_idx_s] <= mem_wword_s;
        end
    end

endmodule

// File: tb/tb_data_sram_like_responder.sv
// ----------------------------------------------------------------------------
// tb_data_sram_like_responder
// Directed bench for data_sram_like_responder. Two instances: u_dut1 with the
// default parameters (DEPTH=4, RESP_LAT=2) and u_dut2 with DEPTH=2,
// RESP_LAT=4 for the throttling case. Inputs change just after the falling
// edge; outputs are checked 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_data_sram_like_responder;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    data_sram_like_responder_if if1 ();
    data_sram_like_responder_if if2 ();

    data_sram_like_responder #(.ADDR_W(10), .DEPTH(4), .RESP_LAT(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    data_sram_like_responder #(.ADDR_W(10), .DEPTH(2), .RESP_LAT(4)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle on u_dut1: drive after the falling edge, settle 1 ns
    task automatic drv1(input logic rq, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [3:0] st,
                        input logic [31:0] wd, input logic stl);
        @(negedge clk);
        if1.req = rq; if1.wr = w; if1.size = sz; if1.addr = a;
        if1.wstrb = st; if1.wdata = wd; if1.stall_in = stl;
        #1;
    endtask

    // One cycle on u_dut2
    task automatic drv2(input logic rq, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [3:0] st,
                        input logic [31:0] wd, input logic stl);
        @(negedge clk);
        if2.req = rq; if2.wr = w; if2.size = sz; if2.addr = a;
        if2.wstrb = st; if2.wdata = wd; if2.stall_in = stl;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if1.req = 1'b0; if1.wr = 1'b0; if1.size = 2'd0; if1.addr = 32'h0;
        if1.wstrb = 4'h0; if1.wdata = 32'h0; if1.stall_in = 1'b0;
        if2.req = 1'b0; if2.wr = 1'b0; if2.size = 2'd0; if2.addr = 32'h0;
        if2.wstrb = 4'h0; if2.wdata = 32'h0; if2.stall_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr_ok",  {31'h0, if1.addr_ok}, 32'h0);
        chk("rst_data_ok",  {31'h0, if1.data_ok}, 32'h0);
        chk("rst_rdata",    if1.rdata,            32'h0);
        chk("rst_err",      {31'h0, if1.err},     32'h0);
        chk("rst_err_addr", if1.err_addr,         32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_addr_ok", {31'h0, if1.addr_ok}, 32'h1);

        // Test 1: word write then read of the same word
        drv1(1'b1, 1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        chk("t1_c0_addr_ok", {31'h0, if1.addr_ok}, 32'h1);
        drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("t1_c1_data_ok", {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t1_c2_data_ok", {31'h0, if1.data_ok}, 32'h1);
        chk("t1_c2_rdata",   if1.rdata,            32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t1_c3_data_ok", {31'h0, if1.data_ok}, 32'h1);
        chk("t1_c3_rdata",   if1.rdata,            32'hDEADBEEF);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t1_c4_data_ok", {31'h0, if1.data_ok}, 32'h0);
        chk("t1_c4_rdata",   if1.rdata,            32'h0);

        // Test 2: byte write into lane 1, read back the merged word
        drv1(1'b1, 1'b1, 2'd0, 32'h11, 4'h2, 32'h0000AA00, 1'b0);
        drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("t2_c1_data_ok", {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t2_c2_rdata",   if1.rdata,            32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t2_c3_data_ok", {31'h0, if1.data_ok}, 32'h1);
        chk("t2_c3_rdata",   if1.rdata,            32'hDEADAAEF);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);

        // Test 4: stall_in holds off acceptance for three cycles
        for (int c = 0; c < 3; c++) begin
            drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b1);
            chk("t4_stall_addr_ok", {31'h0, if1.addr_ok}, 32'h0);
            chk("t4_stall_data_ok", {31'h0, if1.data_ok}, 32'h0);
        end
        drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("t4_c3_addr_ok", {31'h0, if1.addr_ok}, 32'h1);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t4_c4_data_ok", {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t4_c5_data_ok", {31'h0, if1.data_ok}, 32'h1);
        chk("t4_c5_rdata",   if1.rdata,            32'hDEADAAEF);

        // Test 5: misaligned word write then misaligned half read
        drv1(1'b1, 1'b1, 2'd2, 32'h12, 4'hF, 32'h12345678, 1'b0);
        chk("t5_pre_err", {31'h0, if1.err}, 32'h0);
        drv1(1'b1, 1'b0, 2'd1, 32'h21, 4'h0, 32'h0, 1'b0);
        chk("t5_c1_err",      {31'h0, if1.err}, 32'h1);
        chk("t5_c1_err_addr", if1.err_addr,     32'h12);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t5_c2_data_ok",  {31'h0, if1.data_ok}, 32'h1);
        chk("t5_c2_rdata",    if1.rdata,            32'h0);
        chk("t5_c2_err_addr", if1.err_addr,         32'h12);
        drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("t5_c3_data_ok",  {31'h0, if1.data_ok}, 32'h1);
        chk("t5_c3_rdata",    if1.rdata,            32'h0);
        chk("t5_c3_err",      {31'h0, if1.err},     32'h1);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t5_c4_data_ok",  {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t5_c5_data_ok",  {31'h0, if1.data_ok}, 32'h1);
        chk("t5_c5_rdata",    if1.rdata,            32'hDEADAAEF);
        chk("t5_c5_err_addr", if1.err_addr,         32'h12);

        // Test 6: reset pulsed with reads outstanding
        drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);
        drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_rst_addr_ok", {31'h0, if1.addr_ok}, 32'h0);
        chk("t6_rst_data_ok", {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        reset = 1'b0;
        #1;
        chk("t6_c2_data_ok",  {31'h0, if1.data_ok}, 32'h0);
        chk("t6_c2_addr_ok",  {31'h0, if1.addr_ok}, 32'h1);
        chk("t6_c2_err",      {31'h0, if1.err},     32'h0);
        chk("t6_c2_err_addr", if1.err_addr,         32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t6_c3_data_ok",  {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);
        chk("t6_c4_data_ok",  {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t6_c5_data_ok",  {31'h0, if1.data_ok}, 32'h0);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t6_c6_data_ok",  {31'h0, if1.data_ok}, 32'h1);
        chk("t6_c6_rdata",    if1.rdata,            32'hDEADAAEF);

        // Test 3 on u_dut2 (DEPTH=2, RESP_LAT=4): preload word 0, let it drain
        drv2(1'b1, 1'b1, 2'd2, 32'h0, 4'hF, 32'h11111111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drv2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        end
        chk("t3_idle_data_ok", {31'h0, if2.data_ok}, 32'h0);
        drv2(1'b1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t3_c0_addr_ok", {31'h0, if2.addr_ok}, 32'h1);
        drv2(1'b1, 1'b0, 2'd2, 32'h4, 4'h0, 32'h0, 1'b0);
        chk("t3_c1_addr_ok", {31'h0, if2.addr_ok}, 32'h1);
        drv2(1'b1, 1'b0, 2'd2, 32'h8, 4'h0, 32'h0, 1'b0);
        chk("t3_c2_addr_ok", {31'h0, if2.addr_ok}, 32'h0);
        chk("t3_c2_data_ok", {31'h0, if2.data_ok}, 32'h0);
        drv2(1'b1, 1'b0, 2'd2, 32'h8, 4'h0, 32'h0, 1'b0);
        chk("t3_c3_addr_ok", {31'h0, if2.addr_ok}, 32'h0);
        chk("t3_c3_data_ok", {31'h0, if2.data_ok}, 32'h0);
        drv2(1'b1, 1'b0, 2'd2, 32'h8, 4'h0, 32'h0, 1'b0);
        chk("t3_c4_addr_ok", {31'h0, if2.addr_ok}, 32'h1);
        chk("t3_c4_data_ok", {31'h0, if2.data_ok}, 32'h1);
        chk("t3_c4_rdata",   if2.rdata,            32'h11111111);
        drv2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t3_c5_data_ok", {31'h0, if2.data_ok}, 32'h1);
        drv2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t3_c6_data_ok", {31'h0, if2.data_ok}, 32'h0);
        drv2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t3_c7_data_ok", {31'h0, if2.data_ok}, 32'h0);
        drv2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t3_c8_data_ok", {31'h0, if2.data_ok}, 32'h1);
        drv2(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("t3_c9_data_ok", {31'h0, if2.data_ok}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
